rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the two write ports (we1/waddr1/wdata1 and we2/waddr2/wdata2) of the 4-read/2-write register-file RAM among NUM_REQ writeback requesters (ALU0, ALU1, MUL, LDST).
- Uses round-robin grants, up to two per cycle, with a valid/ready handshake toward the requesters.
- Write-port outputs are registered and wired directly into the RAM's write ports.
- Guarantees that the RAM never sees two simultaneous writes to the same address, and never sees a write to address 0.

Parameters:
- NUM_REQ, 4, number of writeback requesters; must be 2..8.
- ADDR_W, 5, register-file address width.
- DATA_W, 32, register data width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- hold_i  in  1  when high, no request is granted; the RAM port is kept idle.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_addr_i  in  NUM_REQ*ADDR_W  flattened destination addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data_i  in  NUM_REQ*DATA_W  flattened write data.
- req_ready_o  out  NUM_REQ  combinational grant; transfer occurs when valid&ready.
- we1_o, we2_o  out  1  registered RAM write enables.
- waddr1_o, waddr2_o  out  ADDR_W  registered RAM write addresses.
- wdata1_o, wdata2_o  out  DATA_W  registered RAM write data.

Behaviour:
- Reset (reset_i=1 at posedge) sets:
  - rr_ptr=0
  - we1_o=we2_o=0
  - waddr*_o=0, wdata*_o=0
- req_ready_o is 0 whenever reset_i or hold_i is high.
- Requester rules:
  - Once valid is asserted, addr and data must be held stable until the request is accepted.
  - ready may depend combinationally on valid; valid must not depend on ready.
- Zero-address requests (valid, addr==0):
  - Always acceptable when hold_i=0.
  - Consume no port, produce no RAM write, and do not affect rr_ptr.
- Grant selection:
  - Eligible requesters are those with valid and addr!=0.
  - They are scanned in cyclic order rr_ptr, rr_ptr+1, …, rr_ptr+NUM_REQ-1 (mod NUM_REQ).
  - The first eligible requester gets port 1 (slot A).
  - The next eligible requester whose addr differs from slot A's addr gets port 2 (slot B).
  - A same-address requester is skipped, stays pending, and is retried next cycle.
  - If only one requester is eligible, it uses port 1 and port 2 stays idle.
- Latency: an accepted request appears on weN_o/waddrN_o/wdataN_o exactly 1 cycle after acceptance; the RAM commits it on the following edge.
- Output update each cycle:
  - we1_o <= slot A granted; we2_o <= slot B granted.
  - waddr/wdata are loaded only when the corresponding grant is made; otherwise they hold their previous values.
- Pointer update:
  - If any port grant was made, rr_ptr <= (index of last port grant + 1) mod NUM_REQ.
  - Otherwise rr_ptr holds.
- Fairness: with all requesters continuously valid and all addresses distinct, every requester is granted at least once per ceil(NUM_REQ/2) cycles.
- Invariant: we1_o & we2_o implies waddr1_o != waddr2_o.
- Invariant: we*_o implies waddr*_o != 0.
- Reset mid-operation: any output write registered in the previous cycle is dropped (we cleared); pending requests stay pending and are re-arbitrated from rr_ptr=0.
- hold_i: freezes rr_ptr and forces we1_o=we2_o=0 in the following cycle.

Optional Feature:
- Macro: RF_WR_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt_o (32 bits), reset to 0.
  - Increments by 1 (wrapping at 2^32) in each cycle where at least one req_valid_i bit is high but its req_ready_o bit is low.
  - hold_i cycles are counted.
- Not defined: the port and its counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/header:
  - RF_ADDR_W=5, RF_DATA_W=32 (taken from the existing `DATA_LEN` convention).
  - Requester index constants REQ_ALU0=0, REQ_ALU1=1, REQ_MUL=2, REQ_LDST=3.
- Sub-module rr_pick2:
  - Purely combinational.
  - Takes eligibility, addresses and rr_ptr.
  - Returns slot A/B valid+index.
  - Handles the same-address exclusion.
- The top level holds the pointer, the output registers, and the optional counter.

Test Plan:
- Reset with all 4 requesters valid (addrs 1,2,3,4; data 0x11..0x44): during reset, ready=0000 and we=0. In the first cycle after reset, ready=0011; the next cycle shows waddr1=1 and waddr2=2. The following grant is ready=1100.
- Requesters 0 and 1 both valid with addr=7, data 0xA/0xB, rr_ptr=0: cycle 1 grants only req0 (we1=1, waddr1=7, we2=0); req1 is granted in the next cycle, so the final RAM value is 0xB.
- Requester 2 valid with addr=0, together with requester 3 at addr=9: both ready in the same cycle; next cycle we1=1 with waddr1=9, and we2=0. rr_ptr becomes 0 (3+1 mod 4).
- hold_i=1 for 3 cycles with req1 valid: ready stays 0 and we stays 0. After hold_i drops, req1 is granted; with RF_WR_ARB_STATS_EN defined, stall_cnt_o=3.
- All 4 requesters continuously valid with distinct addresses for 20 cycles: each requester receives exactly 10 grants and no cycle shows waddr1==waddr2 with both enables high.
- reset_i pulsed in the cycle after a grant to addr 5: we1_o=0 on the next cycle and no write to addr 5 reaches the RAM.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file constants and writeback requester indices for the write-port arbiter.
package rf_write_arbiter_pkg;

    localparam int RF_ADDR_W  = 5;
    localparam int RF_DATA_W  = 32;
    localparam int RF_NUM_REQ = 4;

    localparam int REQ_ALU0 = 0;
    localparam int REQ_ALU1 = 1;
    localparam int REQ_MUL  = 2;
    localparam int REQ_LDST = 3;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_write_arbiter_pick2.sv
// Combinational round-robin picker: first eligible requester from ptr_i takes slot A,
// next eligible one with a different address takes slot B.
module rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]        elig_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [PTR_W-1:0]          ptr_i,
    output logic                      a_vld_o,
    output logic [PTR_W-1:0]          a_idx_o,
    output logic                      b_vld_o,
    output logic [PTR_W-1:0]          b_idx_o
);

    localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [ADDR_W-1:0] a_addr;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = addr_i[g*ADDR_W +: ADDR_W];
    end

    always_comb begin
        a_vld_o = 1'b0;
        a_idx_o = '0;
        b_vld_o = 1'b0;
        b_idx_o = '0;
        a_addr  = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (sum >= NREQ) sum = sum - NREQ;
            idx = sum[PTR_W-1:0];
            if (elig_i[idx]) begin
                if (!a_vld_o) begin
                    a_vld_o = 1'b1;
                    a_idx_o = idx;
                    a_addr  = addr_arr[idx];
                end else if (!b_vld_o && addr_arr[idx] != a_addr) begin
                    // same-address losers stay pending and retry next cycle
                    b_vld_o = 1'b1;
                    b_idx_o = idx;
                end
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the two register-file write ports among NUM_REQ writeback sources.
// Optional stall counter output under RF_WR_ARB_STATS_EN.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = RF_NUM_REQ,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      hold_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
`ifdef RF_WR_ARB_STATS_EN
    output logic [31:0]               stall_cnt_o,
`endif
    output logic                      we1_o,
    output logic                      we2_o,
    output logic [ADDR_W-1:0]         waddr1_o,
    output logic [ADDR_W-1:0]         waddr2_o,
    output logic [DATA_W-1:0]         wdata1_o,
    output logic [DATA_W-1:0]         wdata2_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] nz_addr, elig;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               a_vld, b_vld, grant_en, ga, gb;
    logic [PTR_W-1:0]   a_idx, b_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data_i[g*DATA_W +: DATA_W];
        assign nz_addr[g]  = (addr_arr[g] != '0);
    end

    assign elig     = req_valid_i & nz_addr;
    assign grant_en = ~reset_i & ~hold_i;
    assign ga       = a_vld & grant_en;
    assign gb       = b_vld & grant_en;

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .PTR_W   (PTR_W)
    ) u_pick (
        .elig_i  (elig),
        .addr_i  (req_addr_i),
        .ptr_i   (rr_ptr_q),
        .a_vld_o (a_vld),
        .a_idx_o (a_idx),
        .b_vld_o (b_vld),
        .b_idx_o (b_idx)
    );

    // Writes to r0 are swallowed here: accepted without using a port.
    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = grant_en & req_valid_i[i] &
                             (~nz_addr[i] | (ga & (a_idx == PTR_W'(i))) |
                                            (gb & (b_idx == PTR_W'(i))));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gb) begin
            rr_ptr_d = (b_idx == PTR_W'(NUM_REQ-1)) ? '0 : b_idx + 1'b1;
        end else if (ga) begin
            rr_ptr_d = (a_idx == PTR_W'(NUM_REQ-1)) ? '0 : a_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
            we1_o    <= 1'b0;
            we2_o    <= 1'b0;
            waddr1_o <= '0;
            waddr2_o <= '0;
            wdata1_o <= '0;
            wdata2_o <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we1_o    <= ga;
            we2_o    <= gb;
            if (ga) begin
                waddr1_o <= addr_arr[a_idx];
                wdata1_o <= data_arr[a_idx];
            end
            if (gb) begin
                waddr2_o <= addr_arr[b_idx];
                wdata2_o <= data_arr[b_idx];
            end
        end
    end

`ifdef RF_WR_ARB_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (|(req_valid_i & ~req_ready_o)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a small RAM model fed by the write ports.
module tb_rf_write_arbiter;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         hold_i;
    logic [3:0]   req_valid_i;
    logic [19:0]  req_addr_i;
    logic [127:0] req_data_i;
    logic [3:0]   req_ready_o;
    logic         we1_o, we2_o;
    logic [4:0]   waddr1_o, waddr2_o;
    logic [31:0]  wdata1_o, wdata2_o;
`ifdef RF_WR_ARB_STATS_EN
    logic [31:0]  stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int gcnt [4];
    logic [31:0] rf [32];

    rf_write_arbiter dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .hold_i      (hold_i),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
`ifdef RF_WR_ARB_STATS_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .we1_o       (we1_o),
        .we2_o       (we2_o),
        .waddr1_o    (waddr1_o),
        .waddr2_o    (waddr2_o),
        .wdata1_o    (wdata1_o),
        .wdata2_o    (wdata2_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM write ports are blocked while the core sits in reset
    always @(posedge clk_i) begin
        if (!reset_i) begin
            if (we1_o) rf[waddr1_o] <= wdata1_o;
            if (we2_o) rf[waddr2_o] <= wdata2_o;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid_i[i]        = v;
        req_addr_i[i*5 +: 5]  = a;
        req_data_i[i*32 +: 32] = d;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset_i = 1'b1;
        hold_i  = 1'b0;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(i + 1), 32'(8'h11 * (i + 1)));

        // reset with all four requesters valid
        tick();
        tick();
        chk("rst_ready", 64'(req_ready_o), 64'h0);
        chk("rst_we1", 64'(we1_o), 64'h0);
        chk("rst_we2", 64'(we2_o), 64'h0);
        chk("rst_waddr1", 64'(waddr1_o), 64'h0);
        chk("rst_wdata2", 64'(wdata2_o), 64'h0);
        reset_i = 1'b0;
        #1;
        chk("rr_ready0", 64'(req_ready_o), 64'h3);
        tick();
        set_req(0, 1'b0, 5'd1, 32'h11);
        set_req(1, 1'b0, 5'd2, 32'h22);
        chk("rr_we", 64'({we1_o, we2_o}), 64'h3);
        chk("rr_waddr1", 64'(waddr1_o), 64'd1);
        chk("rr_waddr2", 64'(waddr2_o), 64'd2);
        chk("rr_wdata1", 64'(wdata1_o), 64'h11);
        #1;
        chk("rr_ready1", 64'(req_ready_o), 64'hC);
        tick();
        req_valid_i = '0;
        chk("rr_pair2", 64'({waddr1_o, waddr2_o}), 64'({5'd3, 5'd4}));
        chk("rr_wdata2", 64'(wdata2_o), 64'h44);
        tick();
        chk("idle_we", 64'({we1_o, we2_o}), 64'h0);

        // same-address pair, rr_ptr=0
        set_req(0, 1'b1, 5'd7, 32'hA);
        set_req(1, 1'b1, 5'd7, 32'hB);
        #1;
        chk("same_ready0", 64'(req_ready_o), 64'h1);
        tick();
        set_req(0, 1'b0, 5'd7, 32'hA);
        chk("same_c1", 64'({we1_o, waddr1_o, wdata1_o[7:0], we2_o}), 64'({1'b1, 5'd7, 8'hA, 1'b0}));
        #1;
        chk("same_ready1", 64'(req_ready_o), 64'h2);
        tick();
        set_req(1, 1'b0, 5'd7, 32'hB);
        chk("same_c2", 64'({we1_o, waddr1_o, wdata1_o[7:0], we2_o}), 64'({1'b1, 5'd7, 8'hB, 1'b0}));
        tick();
        chk("same_ram7", 64'(rf[7]), 64'hB);

        // rr_ptr=2: zero-address req2 with req3 at addr 9
        set_req(2, 1'b1, 5'd0, 32'h5);
        set_req(3, 1'b1, 5'd9, 32'h99);
        #1;
        chk("zero_ready", 64'(req_ready_o), 64'hC);
        tick();
        req_valid_i = '0;
        chk("zero_out", 64'({we1_o, waddr1_o, wdata1_o[7:0], we2_o}), 64'({1'b1, 5'd9, 8'h99, 1'b0}));
        set_req(0, 1'b1, 5'd14, 32'h140);
        set_req(1, 1'b1, 5'd15, 32'h150);
        set_req(3, 1'b1, 5'd9,  32'h98);
        #1;
        chk("zero_ptr_wrap", 64'(req_ready_o), 64'h3);
        tick();
        set_req(0, 1'b0, 5'd14, 32'h140);
        set_req(1, 1'b0, 5'd15, 32'h150);
        chk("ptr_wr_addr", 64'({waddr1_o, waddr2_o}), 64'({5'd14, 5'd15}));
        #1;
        chk("ptr_next", 64'(req_ready_o), 64'h8);
        tick();
        req_valid_i = '0;
        tick();
        chk("ram_r0", 64'(rf[0]), 64'h0);

        // hold for three cycles
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        hold_i  = 1'b1;
        set_req(1, 1'b1, 5'd6, 32'h66);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_ready", 64'(req_ready_o), 64'h0);
            tick();
            chk("hold_we", 64'({we1_o, we2_o}), 64'h0);
        end
        hold_i = 1'b0;
        #1;
        chk("hold_release", 64'(req_ready_o), 64'h2);
        tick();
        set_req(1, 1'b0, 5'd6, 32'h66);
        chk("hold_out", 64'({we1_o, waddr1_o, wdata1_o[7:0]}), 64'({1'b1, 5'd6, 8'h66}));
`ifdef RF_WR_ARB_STATS_EN
        chk("stall_cnt", 64'(stall_cnt_o), 64'd3);
`endif

        // fairness, rr_ptr=2 after grant to req1
        for (int i = 0; i < 4; i++) begin
            gcnt[i] = 0;
            set_req(i, 1'b1, 5'(10 + i), 32'(i));
        end
        #1;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 4; i++) if (req_valid_i[i] && req_ready_o[i]) gcnt[i]++;
            tick();
            chk("fair_collide", 64'(we1_o & we2_o & (waddr1_o == waddr2_o)), 64'h0);
            chk("fair_nz", 64'((we1_o & (waddr1_o == 5'd0)) | (we2_o & (waddr2_o == 5'd0))), 64'h0);
        end
        req_valid_i = '0;
        for (int i = 0; i < 4; i++) chk("fair_count", 64'(gcnt[i]), 64'd10);
        tick();

        // reset pulse right after a grant to addr 5
        set_req(0, 1'b1, 5'd5, 32'h55);
        #1;
        chk("rst5_ready", 64'(req_ready_o), 64'h1);
        tick();
        set_req(0, 1'b0, 5'd5, 32'h55);
        chk("rst5_granted", 64'({we1_o, waddr1_o}), 64'({1'b1, 5'd5}));
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rst5_we1", 64'(we1_o), 64'h0);
        tick();
        chk("rst5_ram", 64'(rf[5]), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
